punc_mem_arbiter: RTL and testbench
===================================

PUNC_MEM_ARBITER -- requirements
Module: punc_mem_arbiter

Interface
REQ-001 ADDR_W, 16, memory word-address width.
REQ-002 DATA_W, 16, memory word width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous active-low reset (0 = reset asserted).
REQ-005 c_req  in  1  CPU-port access request.
REQ-006 c_we  in  1  CPU-port write enable (1 = write, 0 = read).
REQ-007 c_addr  in  ADDR_W  CPU-port word address.
REQ-008 c_wdata  in  DATA_W  CPU-port write data.
REQ-009 c_gnt  out  1  CPU request accepted this cycle.
REQ-010 c_done  out  1  CPU transaction complete this cycle.
REQ-011 c_rdata  out  DATA_W  CPU read data, valid with c_done.
REQ-012 d_req  in  1  debug/loader-port access request.
REQ-013 d_we  in  1  debug-port write enable.
REQ-014 d_addr  in  ADDR_W  debug-port word address.
REQ-015 d_wdata  in  DATA_W  debug-port write data.
REQ-016 d_gnt  out  1  debug request accepted this cycle.
REQ-017 d_done  out  1  debug transaction complete this cycle.
REQ-018 d_rdata  out  DATA_W  debug read data, valid with d_done.
REQ-019 mem_en  out  1  memory access strobe.
REQ-020 mem_we  out  1  memory write strobe.
REQ-021 mem_addr  out  ADDR_W  memory word address.
REQ-022 mem_wdata  out  DATA_W  memory write data.
REQ-023 mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe (synchronous-read memory).

Function
REQ-024 FSM states IDLE, ACCESS, RESP; transitions IDLE->ACCESS on any req, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-025 In IDLE with a request: winner's gnt = 1 (combinational, that cycle only); we/addr/wdata and owner id latched at that edge.
REQ-026 Arbitration round-robin: single requester granted immediately; on tie, port not served last wins; last-served = D after reset, so CPU wins first tie.
REQ-027 gnt asserted only in IDLE; at most one of c_gnt/d_gnt and one of c_done/d_done high in any cycle.
REQ-028 ACCESS: mem_en = 1, mem_we = latched we, mem_addr/mem_wdata = latched values.
REQ-029 mem_en = 0 and mem_we = 0 outside ACCESS; mem_addr/mem_wdata hold last latched values.
REQ-030 RESP: owner's done = 1 for one cycle; owner's rdata = mem_rdata for reads, 0 for writes; non-owner rdata = 0; both rdata = 0 outside RESP.
REQ-031 Latency: gnt in cycle T, mem strobe T+1, done T+2; max throughput one transaction per 3 cycles.
REQ-032 Requester holds req/we/addr/wdata stable until gnt; inputs ignored from gnt until done; req still high in a later IDLE is a new request.
REQ-033 req deasserted during ACCESS/RESP does not cancel the transaction; done still issued.

Reset
REQ-034 rst = 0 asynchronously forces IDLE, all outputs 0, latches 0, last-served = D; in-flight transaction abandoned, no done issued.
REQ-035 First rising edge with rst = 1 and a pending req grants per REQ-025.

Structure
REQ-036 State encodings and port-id constants (PORT_C, PORT_D) defined in shared Defines.v.
REQ-037 Two-way round-robin picker is a sub-module punc_rr_arb2 (inputs req[1:0], last; output winner); FSM and latches stay in punc_mem_arbiter.

Verification
REQ-038 Memory preloaded 0x3000=0x1234; c_req read 0x3000 -> c_gnt cycle 1, mem_en/addr 0x3000 cycle 2, c_done with c_rdata 0x1234 cycle 3.
REQ-039 c_req and d_req raised same cycle after reset -> c_gnt first, d_gnt exactly 3 cycles later.
REQ-040 Both req held high for 12 cycles -> grants alternate C,D,C,D; each port granted every 6 cycles.
REQ-041 d write 0xBEEF to 0x0200, then c read 0x0200 -> mem_we only in d's ACCESS cycle; c_rdata 0xBEEF, d_rdata 0.
REQ-042 rst pulled low during ACCESS -> mem_en/mem_we drop immediately, no done; after release, new c_req granted next edge and completes normally.

Source files
------------

// File: rtl/punc_mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Holds the FSM state encoding and the port-id constants used both by the
// arbiter top and by the round-robin picker.
package punc_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  // Port ids double as bit positions in the picker's request vector.
  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/punc_rr_arb2.sv
// Two-way round-robin picker.
// Ports:
//   req    - request vector, bit PORT_C = CPU, bit PORT_D = debug
//   last   - port id served most recently
//   winner - port id to grant (PORT_C when nobody requests; caller qualifies)
module punc_rr_arb2
  import punc_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  always_comb begin
    winner = PORT_C;
    case (req)
      2'b01:   winner = PORT_C;
      2'b10:   winner = PORT_D;
      // Tie: the port not served last goes first.
      2'b11:   winner = (last == PORT_C) ? PORT_D : PORT_C;
      default: winner = PORT_C;
    endcase
  end

endmodule

// File: rtl/punc_mem_arbiter.sv
// Arbitrates a CPU port and a debug/loader port onto one synchronous-read
// memory. Each transaction takes three cycles: grant (IDLE), memory strobe
// (ACCESS), completion with read data (RESP).
// Ports:
//   clk, rst                         - clock, async active-low reset
//   c_req/c_we/c_addr/c_wdata        - CPU request side
//   c_gnt/c_done/c_rdata             - CPU grant, completion, read data
//   d_req/d_we/d_addr/d_wdata        - debug request side
//   d_gnt/d_done/d_rdata             - debug grant, completion, read data
//   mem_en/mem_we/mem_addr/mem_wdata - memory strobe, write, address, data
//   mem_rdata                        - memory read data (one cycle after strobe)
module punc_mem_arbiter
  import punc_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              owner_q;
  logic              last_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic winner;
  logic grant;

  punc_rr_arb2 u_rr (
    .req    ({d_req, c_req}),
    .last   (last_q),
    .winner (winner)
  );

  // rst gates the grant so every output reads 0 while reset is held.
  assign grant = (state_q == StIdle) && (c_req || d_req) && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      owner_q <= PORT_C;
      last_q  <= PORT_D;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= winner;
        last_q  <= winner;
        we_q    <= (winner == PORT_D) ? d_we    : c_we;
        addr_q  <= (winner == PORT_D) ? d_addr  : c_addr;
        wdata_q <= (winner == PORT_D) ? d_wdata : c_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    c_gnt   = 1'b0;
    d_gnt   = 1'b0;
    c_done  = 1'b0;
    d_done  = 1'b0;
    c_rdata = '0;
    d_rdata = '0;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = StAccess;
          c_gnt   = (winner == PORT_C);
          d_gnt   = (winner == PORT_D);
        end
      end
      StAccess: begin
        state_d = StResp;
        mem_en  = 1'b1;
        mem_we  = we_q;
      end
      StResp: begin
        state_d = StIdle;
        if (owner_q == PORT_C) begin
          c_done  = 1'b1;
          c_rdata = we_q ? '0 : mem_rdata;
        end else begin
          d_done  = 1'b1;
          d_rdata = we_q ? '0 : mem_rdata;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Bench for punc_mem_arbiter: directed scenarios with literal expectations,
// then randomized two-port traffic, all checked every cycle against a
// transaction-level model (phase counter, shadow memory, last-served port).
module tb_punc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [15:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_done, d_gnt, d_done, mem_en, mem_we;
  logic [15:0] c_rdata, d_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;

  always #5 clk = ~clk;

  punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_gnt     (c_gnt),
    .c_done    (c_done),
    .c_rdata   (c_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous-read memory attached to the arbiter.
  logic [15:0] bmem [0:65535] = '{default: 16'h0000};
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      bmem[16'h3000] <= 16'h1234;
      mem_init       <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) bmem[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bmem[mem_addr];
    end
  end

  // Reference model state.
  logic [15:0] shadow [0:65535] = '{default: 16'h0000};
  int          m_phase;   // 0 waiting, 1 memory cycle, 2 completion cycle
  logic        m_owner;   // 0 = CPU, 1 = debug
  logic        m_last;
  logic        m_we;
  logic [15:0] m_addr, m_wdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Compare every output against the model, then advance the model to the
  // state it must hold after the coming rising edge.
  task automatic sample();
    logic        e_cg, e_dg, e_cd, e_dd, e_en, e_we, win;
    logic [15:0] e_cr, e_dr;
    @(negedge clk);
    cyc++;
    e_cg = 0; e_dg = 0; e_cd = 0; e_dd = 0; e_en = 0; e_we = 0;
    e_cr = 0; e_dr = 0; win = 0;
    if (!rst) begin
      m_phase = 0; m_owner = 0; m_last = 1; m_we = 0; m_addr = 0; m_wdata = 0;
    end else if (m_phase == 0) begin
      if (c_req || d_req) begin
        win  = (c_req && d_req) ? !m_last : d_req;
        e_cg = !win;
        e_dg = win;
      end
    end else if (m_phase == 1) begin
      e_en = 1;
      e_we = m_we;
    end else begin
      if (m_owner) begin
        e_dd = 1;
        e_dr = m_we ? 16'h0 : shadow[m_addr];
      end else begin
        e_cd = 1;
        e_cr = m_we ? 16'h0 : shadow[m_addr];
      end
    end
    chk("c_gnt", c_gnt, e_cg);
    chk("d_gnt", d_gnt, e_dg);
    chk("c_done", c_done, e_cd);
    chk("d_done", d_done, e_dd);
    chk("c_rdata", c_rdata, e_cr);
    chk("d_rdata", d_rdata, e_dr);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    if (rst) begin
      if (m_phase == 0 && (c_req || d_req)) begin
        m_phase = 1;
        m_owner = win;
        m_last  = win;
        m_we    = win ? d_we    : c_we;
        m_addr  = win ? d_addr  : c_addr;
        m_wdata = win ? d_wdata : c_wdata;
      end else if (m_phase == 1) begin
        if (m_we) shadow[m_addr] = m_wdata;
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(3))
      0:       return 16'h3000;
      1:       return 16'h0200;
      default: return 16'h0010 + 16'($urandom_range(3));
    endcase
  endfunction

  initial begin
    int   cq[$];
    int   dq[$];
    logic gc, gd;
    shadow[16'h3000] = 16'h1234;
    m_phase = 0; m_owner = 0; m_last = 1; m_we = 0; m_addr = 0; m_wdata = 0;
    rst = 0;
    c_req = 1; c_we = 0; c_addr = 16'h3000; c_wdata = 0;
    d_req = 1; d_we = 1; d_addr = 16'h0001; d_wdata = 16'h5555;

    // Reset held with requests pending: everything stays quiet.
    sample(); chk("rst c_gnt", c_gnt, 0); chk("rst d_gnt", d_gnt, 0); adv();
    sample(); chk("rst mem_en", mem_en, 0); chk("rst mem_addr", mem_addr, 0); adv();

    // Single CPU read of the preloaded word.
    d_req = 0; rst = 1;
    sample(); chk("A c_gnt", c_gnt, 1); adv();
    c_req = 0;
    sample(); chk("A mem_en", mem_en, 1); chk("A mem_addr", mem_addr, 16'h3000); adv();
    sample(); chk("A c_done", c_done, 1); chk("A c_rdata", c_rdata, 16'h1234); adv();

    // Fresh reset, then both ports request together and hold for 12 cycles.
    rst = 0;
    sample(); adv();
    rst = 1;
    c_req = 1; c_we = 0; c_addr = 16'h3000;
    d_req = 1; d_we = 0; d_addr = 16'h0200;
    for (int i = 0; i < 12; i++) begin
      sample();
      if (c_gnt) cq.push_back(cyc);
      if (d_gnt) dq.push_back(cyc);
      adv();
    end
    c_req = 0; d_req = 0;
    chk("B c grants", cq.size(), 2);
    chk("B d grants", dq.size(), 2);
    if (cq.size() >= 2 && dq.size() >= 2) begin
      chk("B c first", cq[0] < dq[0], 1);
      chk("B d lag", dq[0] - cq[0], 3);
      chk("B c period", cq[1] - cq[0], 6);
      chk("B d period", dq[1] - dq[0], 6);
    end

    // Debug write, then CPU read of the same word.
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'hBEEF;
    sample(); chk("C d_gnt", d_gnt, 1); adv();
    d_req = 0;
    sample(); chk("C mem_we", mem_we, 1); chk("C mem_wdata", mem_wdata, 16'hBEEF); adv();
    sample(); chk("C d_done", d_done, 1); chk("C d_rdata", d_rdata, 0); adv();
    c_req = 1; c_we = 0; c_addr = 16'h0200;
    sample(); chk("C c_gnt", c_gnt, 1); adv();
    c_req = 0;
    sample(); chk("C rd mem_we", mem_we, 0); adv();
    sample(); chk("C c_rdata", c_rdata, 16'hBEEF); chk("C c d_rdata", d_rdata, 0); adv();

    // Reset asserted during the memory cycle of a CPU write.
    c_req = 1; c_we = 1; c_addr = 16'h0055; c_wdata = 16'h0077;
    sample(); adv();
    c_req = 0;
    rst = 0;
    #1;
    chk("D mem_en drop", mem_en, 0);
    chk("D mem_we drop", mem_we, 0);
    sample(); adv();
    sample(); chk("D no done", c_done, 0); adv();
    rst = 1;
    c_req = 1; c_we = 0; c_addr = 16'h0055;
    sample(); chk("D c_gnt", c_gnt, 1); adv();
    c_req = 0;
    sample(); adv();
    sample(); chk("D c_done", c_done, 1); chk("D c_rdata", c_rdata, 0); adv();

    // Randomized traffic; fields change only right after a grant.
    for (int i = 0; i < 400; i++) begin
      sample();
      gc = c_gnt;
      gd = d_gnt;
      adv();
      if (!rst) rst = 1;
      else if ($urandom_range(99) == 0) rst = 0;
      if (gc || !c_req) begin
        if ($urandom_range(9) < 4) begin
          c_req = 1; c_we = 1'($urandom_range(1));
          c_addr = pick_addr(); c_wdata = 16'($urandom);
        end else begin
          c_req = 0;
        end
      end
      if (gd || !d_req) begin
        if ($urandom_range(9) < 4) begin
          d_req = 1; d_we = 1'($urandom_range(1));
          d_addr = pick_addr(); d_wdata = 16'($urandom);
        end else begin
          d_req = 0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
